// File: rtl/score_fetch_ctrl.sv
// Glyph-ROM fetch controller for two score requesters: round-robin grant,
// row-burst address issue, and a one-cycle-delayed beat stream back to the owner.
module score_fetch_ctrl #(
  parameter int DIG_MAX = 9,
  parameter int LEN_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       digit0,
  input  logic [3:0]       digit1,
  input  logic [5:0]       row0,
  input  logic [5:0]       row1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [9:0]       rom_addr,
  output logic             rom_en,
  input  logic [7:0]       rom_data,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             rd_err,
  output logic             rd_id,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [3:0]     DMAX = 4'(DIG_MAX);
  localparam logic [LEN_W:0] FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] ONE  = {{LEN_W{1'b0}}, 1'b1};

  state_t           r_state, n_state;
  logic             r_rdy;
  logic [3:0]       r_dig, n_dig;
  logic [5:0]       r_row, n_row;
  logic [LEN_W:0]   r_cnt, n_cnt;
  logic             r_bad, n_bad;
  logic             r_id, n_id;
  logic             r_lastg, n_lastg;
  logic             r_gnt0, n_gnt0, r_gnt1, n_gnt1;
  logic [9:0]       r_addr, n_addr;
  logic             r_en, n_en;
  logic             r_iss, n_iss, r_iss_last, n_iss_last;
  logic             r_vld, r_last, r_err, r_rid;

  logic             w_pick;
  logic [3:0]       w_dig;
  logic [5:0]       w_row;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W:0]   w_n;
  logic             w_ok;

  // Both asking: the side not granted last time wins.
  assign w_pick = req1 & (~req0 | ~r_lastg);
  assign w_dig  = w_pick ? digit1 : digit0;
  assign w_row  = w_pick ? row1   : row0;
  assign w_len  = w_pick ? len1   : len0;
  assign w_n    = (w_len == '0) ? FULL : {1'b0, w_len};
  assign w_ok   = (w_dig <= DMAX);

  always_comb begin
    n_state    = r_state;
    n_dig      = r_dig;
    n_row      = r_row;
    n_cnt      = r_cnt;
    n_bad      = r_bad;
    n_id       = r_id;
    n_lastg    = r_lastg;
    n_gnt0     = 1'b0;
    n_gnt1     = 1'b0;
    n_addr     = 10'd0;
    n_en       = 1'b0;
    n_iss      = 1'b0;
    n_iss_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rdy && (req0 || req1)) begin
          n_state    = ISSUE;
          n_gnt0     = ~w_pick;
          n_gnt1     = w_pick;
          n_id       = w_pick;
          n_lastg    = w_pick;
          n_dig      = w_dig;
          n_bad      = ~w_ok;
          n_iss      = 1'b1;
          n_iss_last = (w_n == ONE);
          n_en       = w_ok;
          n_addr     = w_ok ? {w_dig, w_row} : 10'd0;
          n_row      = w_row + 6'd1;
          n_cnt      = w_n - ONE;
        end
      end
      ISSUE: begin
        // r_cnt holds addresses still to issue after the current one.
        if (r_cnt != '0) begin
          n_iss      = 1'b1;
          n_iss_last = (r_cnt == ONE);
          n_en       = ~r_bad;
          n_addr     = r_bad ? 10'd0 : {r_dig, r_row};
          n_row      = r_row + 6'd1;
          n_cnt      = r_cnt - ONE;
        end else begin
          n_state = DRAIN;
        end
      end
      DRAIN:   n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rdy      <= 1'b0;
      r_dig      <= '0;
      r_row      <= '0;
      r_cnt      <= '0;
      r_bad      <= 1'b0;
      r_id       <= 1'b0;
      r_lastg    <= 1'b1;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_addr     <= '0;
      r_en       <= 1'b0;
      r_iss      <= 1'b0;
      r_iss_last <= 1'b0;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_rid      <= 1'b0;
    end else begin
      r_state    <= n_state;
      r_rdy      <= 1'b1;
      r_dig      <= n_dig;
      r_row      <= n_row;
      r_cnt      <= n_cnt;
      r_bad      <= n_bad;
      r_id       <= n_id;
      r_lastg    <= n_lastg;
      r_gnt0     <= n_gnt0;
      r_gnt1     <= n_gnt1;
      r_addr     <= n_addr;
      r_en       <= n_en;
      r_iss      <= n_iss;
      r_iss_last <= n_iss_last;
      r_vld      <= r_iss;
      r_last     <= r_iss_last;
      r_err      <= r_iss & r_bad;
      r_rid      <= r_iss & r_id;
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign rom_addr = r_addr;
  assign rom_en   = r_en;
  assign rd_valid = r_vld;
  assign rd_last  = r_last;
  assign rd_err   = r_err;
  assign rd_id    = r_rid;
  assign rd_data  = (r_vld && !r_err) ? rom_data : 8'h00;
  assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_score_fetch_ctrl.sv
// Scoreboard bench for score_fetch_ctrl: expected addresses and beats are queued
// at stimulus time and checked by a negedge monitor; tasks check grants inline.
module tb_score_fetch_ctrl;
  localparam int DIG_MAX = 9;
  localparam int LEN_W   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [3:0]       digit0 = '0, digit1 = '0;
  logic [5:0]       row0 = '0, row1 = '0;
  logic [LEN_W-1:0] len0 = '0, len1 = '0;
  logic             gnt0, gnt1, rom_en, rd_valid, rd_last, rd_err, rd_id, busy;
  logic [9:0]       rom_addr;
  logic [7:0]       rom_data = 8'h00;
  logic [7:0]       rd_data;

  score_fetch_ctrl #(.DIG_MAX(DIG_MAX), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .digit0(digit0), .digit1(digit1), .row0(row0), .row1(row1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .rd_err(rd_err), .rd_id(rd_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [9:0] a);
    return a[7:0] ^ {a[9:6], 4'h3};
  endfunction

  // One-cycle ROM; junk when not enabled so error beats must mask it.
  always @(posedge clk) rom_data <= rom_en ? rom_fn(rom_addr) : 8'hA5;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
    logic       id;
  } beat_t;

  beat_t       bq[$];
  logic [9:0]  aq[$];
  int          total = 0;
  int          bad = 0;
  logic        inburst = 1'b0;

  task automatic push_burst(input logic id, input logic [3:0] dg,
                            input logic [5:0] row, input logic [2:0] ln);
    int n;
    logic ok;
    logic [5:0] r;
    beat_t b;
    n  = (ln == 3'd0) ? 8 : int'(ln);
    ok = (int'(dg) <= DIG_MAX);
    for (int i = 0; i < n; i++) begin
      r      = row + 6'(i);
      b.id   = id;
      b.last = (i == n - 1);
      b.err  = ~ok;
      b.data = ok ? rom_fn({dg, r}) : 8'h00;
      bq.push_back(b);
      if (ok) aq.push_back({dg, r});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      inburst = 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        total++;
        if ((gnt0 && gnt1) || inburst) begin
          bad++;
          $display("FAIL grant_overlap: gnt0=%0b gnt1=%0b inburst=%0b, want single grant outside burst",
                   gnt0, gnt1, inburst);
        end
        inburst = 1'b1;
      end
      total++;
      if (busy !== inburst) begin
        bad++;
        $display("FAIL busy: got %0b want %0b at %0t", busy, inburst, $time);
      end
      if (rom_en) begin
        total++;
        if (aq.size() == 0) begin
          bad++;
          $display("FAIL rom_addr_extra: got rom_en with addr %h, none expected", rom_addr);
        end else begin
          logic [9:0] ea;
          ea = aq.pop_front();
          if (rom_addr !== ea) begin
            bad++;
            $display("FAIL rom_addr: got %h want %h", rom_addr, ea);
          end
        end
      end
      if (rd_valid) begin
        total++;
        if (bq.size() == 0) begin
          bad++;
          $display("FAIL beat_extra: got beat data=%h, none expected", rd_data);
        end else begin
          beat_t eb;
          eb = bq.pop_front();
          if ({rd_data, rd_last, rd_err, rd_id} !== {eb.data, eb.last, eb.err, eb.id}) begin
            bad++;
            $display("FAIL beat: got data=%h last=%0b err=%0b id=%0b want data=%h last=%0b err=%0b id=%0b",
                     rd_data, rd_last, rd_err, rd_id, eb.data, eb.last, eb.err, eb.id);
          end
        end
        if (rd_last) inburst = 1'b0;
      end else begin
        total++;
        if ({rd_data, rd_last, rd_err} !== 10'd0) begin
          bad++;
          $display("FAIL idle_beat: got data=%h last=%0b err=%0b want zeros", rd_data, rd_last, rd_err);
        end
      end
    end
  end

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      done = (bq.size() == 0) && (aq.size() == 0) && !busy;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL idle_timeout: beats left=%0d addrs left=%0d busy=%0b", bq.size(), aq.size(), busy);
      bq.delete();
      aq.delete();
    end
  endtask

  task automatic run_burst(input logic id, input logic [3:0] dg,
                           input logic [5:0] row, input logic [2:0] ln);
    bit got;
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; digit1 = dg; row1 = row; len1 = ln; end
    else    begin req0 = 1'b1; digit0 = dg; row0 = row; len0 = ln; end
    push_burst(id, dg, row, ln);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = gnt0 || gnt1;
    end
    total++;
    if (!got || gnt0 !== ~id || gnt1 !== id) begin
      bad++;
      $display("FAIL grant: got gnt0=%0b gnt1=%0b seen=%0b want requester %0b", gnt0, gnt1, got, id);
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; digit0 = 4'd0; row0 = 6'd0; len0 = 3'd1;
    #12;
    total++;
    if ({gnt0, gnt1, rom_addr, rom_en, rd_data, rd_valid, rd_last, rd_err, rd_id, busy} !== 26'd0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%0b%0b addr=%h en=%0b data=%h vld=%0b busy=%0b want all 0",
               gnt0, gnt1, rom_addr, rom_en, rd_data, rd_valid, busy);
    end
    push_burst(1'b0, 4'd0, 6'd0, 3'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (gnt0 !== 1'b0) begin
      bad++;
      $display("FAIL first_grant_early: gnt0=%0b after first edge, want 0", gnt0);
    end
    @(negedge clk);
    total++;
    if (gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL first_grant: gnt0=%0b after second edge, want 1", gnt0);
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    wait_idle();
  endtask

  task automatic test_round_robin();
    bit got;
    logic gid;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    digit0 = 4'd1; row0 = 6'd0;  len0 = 3'd2;
    digit1 = 4'd2; row1 = 6'd10; len1 = 3'd3;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push_burst(1'b0, 4'd1, 6'd0, 3'd2);
      else            push_burst(1'b1, 4'd2, 6'd10, 3'd3);
    end
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        got = gnt0 || gnt1;
      end
      gid = gnt1;
      total++;
      if (!got || gid !== 1'(i % 2)) begin
        bad++;
        $display("FAIL rr_grant%0d: got gnt0=%0b gnt1=%0b seen=%0b want requester %0d", i, gnt0, gnt1, got, i % 2);
      end
      @(posedge clk); #1;
      if (gid) req1 = 1'b0; else req0 = 1'b0;
      @(posedge clk); #1;
      if (i < 4) begin
        if (gid) req1 = 1'b1; else req0 = 1'b1;
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bit got;
    int beats;
    @(posedge clk); #1;
    req0 = 1'b1; digit0 = 4'd1; row0 = 6'd0; len0 = 3'd0;
    push_burst(1'b0, 4'd1, 6'd0, 3'd0);
    got = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 3; c++) begin
      @(negedge clk);
      if (gnt0) begin
        got = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
      end
      if (rd_valid) beats++;
    end
    total++;
    if (!got || beats != 3) begin
      bad++;
      $display("FAIL mid_setup: grant seen=%0b beats=%0d want grant and 3 beats", got, beats);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({gnt0, gnt1, rom_addr, rom_en, rd_data, rd_valid, rd_last, rd_err, rd_id, busy} !== 26'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: addr=%h en=%0b data=%h vld=%0b busy=%0b want all 0",
               rom_addr, rom_en, rd_data, rd_valid, busy);
    end
    req0 = 1'b0;
    bq.delete();
    aq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_burst(1'b0, 4'd2, 6'd3, 3'd3);
  endtask

  task automatic test_rom_busy();
    bit got;
    int cnt;
    @(posedge clk); #1;
    req0 = 1'b1; digit0 = 4'd0; row0 = 6'd10; len0 = 3'd5;
    push_burst(1'b0, 4'd0, 6'd10, 3'd5);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      got = gnt0;
    end
    cnt = (got && busy) ? 1 : 0;
    @(posedge clk); #1;
    req0 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    total++;
    if (cnt != 6) begin
      bad++;
      $display("FAIL busy_span: got %0d cycles want 6", cnt);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    run_burst(1'b0, 4'd3, 6'd5, 3'd2);
    run_burst(1'b1, 4'd7, 6'd62, 3'd4);
    run_burst(1'b0, 4'd12, 6'd0, 3'd0);
    run_burst(1'b1, 4'd9, 6'd63, 3'd1);
    test_round_robin();
    test_reset_mid();
    test_rom_busy();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_fetch_ctrl.md
SCORE_FETCH_CTRL -- requirements
Module: score_fetch_ctrl

Interface
REQ-001 Parameter DIG_MAX, default 9: highest legal digit code; codes above it are invalid.
REQ-002 Parameter LEN_W, default 3: burst-length field width; 0 encodes 2**LEN_W rows.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0, req1  input  1 each  fetch request from requester 0 (X score) and requester 1 (O score).
REQ-006 digit0, digit1  input  4 each  glyph digit per requester.
REQ-007 row0, row1  input  6 each  starting glyph row per requester.
REQ-008 len0, len1  input  LEN_W each  rows to fetch per requester.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse; request fields sampled on it.
REQ-010 rom_addr  output  10  glyph ROM address {digit, row}.
REQ-011 rom_en  output  1  high when rom_addr carries a real fetch.
REQ-012 rom_data  input  8  ROM data, valid one cycle after its address.
REQ-013 rd_data  output  8  returned glyph row.
REQ-014 rd_valid, rd_last, rd_err  output  1 each  beat valid, final beat of burst, invalid-digit beat.
REQ-015 rd_id  output  1  requester owning the current beat.
REQ-016 busy  output  1  high from grant until final beat delivered.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN; reset state IDLE.
REQ-018 IDLE: a request sampled at edge k produces gnt and the first rom_addr in cycle k+1, and state ISSUE.
REQ-019 Requester holds req and fields stable until its gnt; req deasserts no later than the cycle after gnt; a req still high in IDLE is a new request.
REQ-020 Arbitration round-robin: one requester asking wins; both asking, the one not granted last wins; after reset requester 0 has priority.
REQ-021 Exactly one gnt per burst; never both gnt0 and gnt1 in one cycle.
REQ-022 ISSUE: one address per cycle, rom_addr = {digit, row_cnt}, row_cnt starts at sampled row and increments by 1.
REQ-023 Row counter is 6-bit and wraps 63 -> 0 within the same digit.
REQ-024 After len addresses (8 when len = 0) move to DRAIN; DRAIN lasts one cycle, then IDLE.
REQ-025 Requests arriving in ISSUE or DRAIN wait; none granted before IDLE is re-entered.
REQ-026 rd_valid = rom_en delayed one cycle; rd_data = rom_data on those beats; rd_id constant per burst.
REQ-027 rd_last high only with the final beat of each burst; len = 1 gives a single beat with rd_last high.
REQ-028 Digit > DIG_MAX: grant and timing unchanged, rom_en held 0, rom_addr 0, each beat rd_valid = 1, rd_data = 0x00, rd_err = 1.
REQ-029 Legal-digit beats have rd_err = 0; outputs other than rd_valid beats hold rd_data, rd_err, rd_last at 0.
REQ-030 busy high from gnt cycle through the rd_last cycle inclusive.

Reset
REQ-031 rst_n low immediately forces all outputs to 0, state IDLE, row/len counters 0, last-grant pointer to requester 1 (so requester 0 wins first).
REQ-032 Reset mid-burst discards the burst; no further beats of it after rst_n rises.
REQ-033 First grant possible at the second rising edge after rst_n deasserts.

Verification
REQ-034 req0 digit 3 row 5 len 2 -> gnt0 one cycle; rom_addr 0x0C5, 0x0C6 on consecutive cycles; two rd_valid beats, rd_id 0, rd_last on second.
REQ-035 req0 and req1 together, repeated three times -> grants alternate 0,1,0 (after reset), bursts never overlap.
REQ-036 req1 digit 7 row 62 len 4 -> rom_addr 0x1FE, 0x1FF, 0x1C0, 0x1C1; four beats, rd_id 1.
REQ-037 req0 digit 12 len 0 -> eight beats rd_data 0x00 rd_err 1, rom_en never high, rd_last on eighth.
REQ-038 rst_n low during third beat of len-8 burst -> outputs 0 at once; no stale beats after release; next req0 serviced normally.
REQ-039 ROM model with 1-cycle latency returning digit 0 rows -> rd_data matches model per address, busy high exactly from gnt to rd_last.
